// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce.
// Rows are synchronized, columns are driven one at a time on slow sample ticks,
// and an accepted key produces its code on value with a one-cycle key_flag pulse.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned DEB_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] value,
    output logic       key_flag
);

    localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W  = $clog2(DEB_TICKS + 1);

    localparam logic [TICK_W-1:0] TickLast  = TICK_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DebTarget = DEB_W'(DEB_TICKS);
    localparam logic [DEB_W-1:0]  DebMax    = '1;
    localparam logic [DEB_W-1:0]  DebOne    = DEB_W'(1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StScan     = 3'd1;
    localparam logic [2:0] StPressDeb = 3'd2;
    localparam logic [2:0] StHeld     = 3'd3;
    localparam logic [2:0] StRelDeb   = 3'd4;

    localparam logic [3:0] ColNone  = 4'b0000;
    localparam logic [3:0] ColFirst = 4'b1110;

    logic [3:0]        r_row_meta;
    logic [3:0]        r_row_sync;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [2:0]        r_state;
    logic [3:0]        r_col;
    logic [1:0]        r_row_idx;
    logic [1:0]        r_col_idx;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [3:0]        r_value;
    logic              r_key_flag;

    logic              w_tick;
    logic              w_row_any_low;
    logic [1:0]        w_row_first;
    logic              w_key_low;
    logic [DEB_W-1:0]  w_deb_inc;
    logic [2:0]        w_state_nxt;
    logic [3:0]        w_col_nxt;
    logic [1:0]        w_row_idx_nxt;
    logic [1:0]        w_col_idx_nxt;
    logic [DEB_W-1:0]  w_deb_nxt;
    logic [3:0]        w_value_nxt;
    logic              w_flag_nxt;

    // Two-flop synchronizer for the asynchronous row lines (idle level is all ones).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    // Free-running sample divider; the FSM only moves on its terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    assign w_tick        = (r_tick_cnt == TickLast);
    assign w_row_any_low = ~&r_row_sync;
    assign w_key_low     = ~r_row_sync[r_row_idx];
    assign w_deb_inc     = (r_deb_cnt == DebMax) ? r_deb_cnt : r_deb_cnt + DebOne;

    // Lowest-index low row wins when several rows conduct in the driven column.
    always_comb begin
        w_row_first = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_row_sync[i]) begin
                w_row_first = 2'(i);
            end
        end
    end

    // Scan/debounce FSM next-state logic, evaluated only on sample ticks.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_row_idx_nxt = r_row_idx;
        w_col_idx_nxt = r_col_idx;
        w_deb_nxt     = r_deb_cnt;
        w_value_nxt   = r_value;
        w_flag_nxt    = 1'b0;
        if (w_tick) begin
            case (r_state)
                StIdle: begin
                    // All columns driven, so any key anywhere pulls a row low.
                    if (w_row_any_low) begin
                        w_state_nxt   = StScan;
                        w_col_nxt     = ColFirst;
                        w_col_idx_nxt = 2'd0;
                    end
                end
                StScan: begin
                    if (w_row_any_low) begin
                        w_state_nxt   = StPressDeb;
                        w_row_idx_nxt = w_row_first;
                        w_deb_nxt     = DebOne;
                    end else if (r_col_idx == 2'd3) begin
                        w_state_nxt = StIdle;
                        w_col_nxt   = ColNone;
                    end else begin
                        w_col_idx_nxt = r_col_idx + 2'd1;
                        w_col_nxt     = {r_col[2:0], 1'b1};
                    end
                end
                StPressDeb: begin
                    if (w_key_low) begin
                        if (w_deb_inc >= DebTarget) begin
                            w_state_nxt = StHeld;
                            w_value_nxt = {r_row_idx, r_col_idx};
                            w_flag_nxt  = 1'b1;
                            w_deb_nxt   = '0;
                        end else begin
                            w_deb_nxt = w_deb_inc;
                        end
                    end else begin
                        w_state_nxt = StIdle;
                        w_col_nxt   = ColNone;
                        w_deb_nxt   = '0;
                    end
                end
                StHeld: begin
                    // Only the accepted key's row is watched; other keys are ignored.
                    if (!w_key_low) begin
                        w_state_nxt = StRelDeb;
                        w_deb_nxt   = DebOne;
                    end
                end
                StRelDeb: begin
                    if (!w_key_low) begin
                        if (w_deb_inc >= DebTarget) begin
                            w_state_nxt = StIdle;
                            w_col_nxt   = ColNone;
                            w_deb_nxt   = '0;
                        end else begin
                            w_deb_nxt = w_deb_inc;
                        end
                    end else begin
                        w_state_nxt = StHeld;
                        w_deb_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                    w_col_nxt   = ColNone;
                    w_deb_nxt   = '0;
                end
            endcase
        end
    end

    // FSM and output registers; reset aborts any press in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_col      <= ColNone;
            r_row_idx  <= 2'd0;
            r_col_idx  <= 2'd0;
            r_deb_cnt  <= '0;
            r_value    <= 4'd0;
            r_key_flag <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_row_idx  <= w_row_idx_nxt;
            r_col_idx  <= w_col_idx_nxt;
            r_deb_cnt  <= w_deb_nxt;
            r_value    <= w_value_nxt;
            r_key_flag <= w_flag_nxt;
        end
    end

    assign col      = r_col;
    assign value    = r_value;
    assign key_flag = r_key_flag;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed test of keypad_scanner with SCAN_DIV=4, DEB_TICKS=3.
// A small keypad model turns the pressed-key mask and col drives into row levels.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  value;
    logic        key_flag;

    logic [15:0] keys;  // bit 4*r+c set = key (r,c) pressed
    int          n_checks;
    int          n_errors;
    int          flag_cnt;
    int          dbl_cnt;
    logic        prev_flag;

    keypad_scanner #(
        .SCAN_DIV  (4),
        .DEB_TICKS (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .value    (value),
        .key_flag (key_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keypad matrix: a pressed key pulls its row low when its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    // Count key_flag pulses and any back-to-back high cycles.
    always @(posedge clk) begin
        if (key_flag) begin
            flag_cnt <= flag_cnt + 1;
            if (prev_flag) begin
                dbl_cnt <= dbl_cnt + 1;
            end
        end
        prev_flag <= key_flag;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n sample ticks (4 clocks each) and land on a falling edge.
    task automatic ticks(input int n);
        repeat (4 * n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        flag_cnt  = 0;
        dbl_cnt   = 0;
        prev_flag = 1'b0;
        keys      = 16'h0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);

        check("reset_col", 32'(col), 32'h0);
        check("reset_value", 32'(value), 32'h0);
        check("reset_flag", 32'(key_flag), 32'h0);

        // Release reset on a falling edge; ticks fall every 4th rising edge after this.
        rst = 1'b0;
        ticks(2);
        check("idle_col_no_key", 32'(col), 32'h0);

        // Press r=2,c=1: detected in column 1 on the 3rd tick, accepted on the 5th.
        keys[9] = 1'b1;
        ticks(4);
        check("p1_col_in_debounce", 32'(col), 32'hD);
        check("p1_no_flag_yet", 32'(flag_cnt), 32'd0);
        ticks(2);
        check("p1_flag_count", 32'(flag_cnt), 32'd1);
        check("p1_value", 32'(value), 32'd9);
        ticks(4);
        keys = 16'h0;
        ticks(2);
        check("p1_col_rel_deb", 32'(col), 32'hD);
        ticks(1);
        check("p1_col_after_release", 32'(col), 32'h0);
        check("p1_flag_after_release", 32'(flag_cnt), 32'd1);

        // Same key as a glitch: only 2 ticks seen in column 1, then gone.
        keys[9] = 1'b1;
        ticks(4);
        keys = 16'h0;
        ticks(1);
        check("glitch_col_idle", 32'(col), 32'h0);
        ticks(4);
        check("glitch_no_flag", 32'(flag_cnt), 32'd1);
        check("glitch_value_kept", 32'(value), 32'd9);

        // Long hold of r=0,c=3: one flag only.
        keys[3] = 1'b1;
        ticks(6);
        check("hold_col3_driven", 32'(col), 32'h7);
        ticks(44);
        check("hold_flag_count", 32'(flag_cnt), 32'd2);
        check("hold_value", 32'(value), 32'd3);
        check("hold_no_double", 32'(dbl_cnt), 32'd0);
        keys = 16'h0;
        ticks(4);
        check("hold_col_after_release", 32'(col), 32'h0);
        check("hold_flag_after_release", 32'(flag_cnt), 32'd2);

        // Simultaneous r=1,c=2 and r=3,c=0: column 0 is reached first.
        keys[6]  = 1'b1;
        keys[12] = 1'b1;
        ticks(10);
        check("multi_value", 32'(value), 32'd12);
        check("multi_flag_count", 32'(flag_cnt), 32'd3);
        keys = 16'h0;
        ticks(4);
        check("multi_col_after_release", 32'(col), 32'h0);

        // Reset in the middle of debouncing r=3,c=3, then a clean press.
        keys[15] = 1'b1;
        ticks(6);
        check("rst_pre_col", 32'(col), 32'h7);
        rst = 1'b1;
        #1;
        check("rst_abort_col", 32'(col), 32'h0);
        check("rst_abort_value", 32'(value), 32'h0);
        check("rst_abort_flag", 32'(key_flag), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_no_flag", 32'(flag_cnt), 32'd3);
        ticks(8);
        check("rst_repress_flag", 32'(flag_cnt), 32'd4);
        check("rst_repress_value", 32'(value), 32'd15);
        keys = 16'h0;
        ticks(4);

        // Release bounce on r=2,c=1: 1,0,1 across ticks, then stable release.
        keys[9] = 1'b1;
        ticks(6);
        check("bounce_flag", 32'(flag_cnt), 32'd5);
        check("bounce_value", 32'(value), 32'd9);
        keys = 16'h0;
        ticks(1);
        keys[9] = 1'b1;
        ticks(1);
        check("bounce_back_held_col", 32'(col), 32'hD);
        keys = 16'h0;
        ticks(1);
        check("bounce_rel_deb1_col", 32'(col), 32'hD);
        ticks(1);
        check("bounce_rel_deb2_col", 32'(col), 32'hD);
        ticks(1);
        check("bounce_idle_col", 32'(col), 32'h0);
        check("bounce_no_extra_flag", 32'(flag_cnt), 32'd5);
        check("final_no_double", 32'(dbl_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles per sample tick (1 ms at 100 MHz).
REQ-002 Parameter DEB_TICKS, default 20, consecutive stable sample ticks required to accept a press or a release.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port row  input  4  keypad row lines, active-low (0 = key in that row conducting), pulled up off-chip.
REQ-006 Port col  output  4  keypad column drives, active-low (0 = column driven).
REQ-007 Port value  output  4  code of last accepted key, value = 4*r + c (r = row index, c = column index, bit 0 = index 0).
REQ-008 Port key_flag  output  1  one-cycle pulse marking a newly accepted key; value is valid in the same cycle.

Function
REQ-009 row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized copy only.
REQ-010 A free-running tick counter SHALL count 0..SCAN_DIV-1 and assert tick for one cycle at SCAN_DIV-1, then wrap to 0.
REQ-011 All FSM transitions SHALL occur only on tick cycles, except reset.
REQ-012 FSM states SHALL be IDLE, SCAN, PRESS_DEB, HELD and REL_DEB, encoded in 3 bits.
REQ-013 IDLE: col = 4'b0000; on tick with any synchronized row bit = 0, go to SCAN with col = 4'b1110 (column 0).
REQ-014 SCAN: on tick, if any row bit = 0, latch c = current column and r = lowest-index low row bit, then go to PRESS_DEB with debounce count = 1.
REQ-015 SCAN: on tick with no row low, rotate to the next column (1110->1101->1011->0111); after column 3 return to IDLE with col = 4'b0000.
REQ-016 PRESS_DEB: col is held; on each tick, if row bit r is still 0, increment the count, otherwise return to IDLE.
REQ-017 PRESS_DEB: when the count reaches DEB_TICKS, load value = 4*r + c, pulse key_flag for exactly one cycle (that same tick cycle) and go to HELD.
REQ-018 HELD: col is held; on tick with row bit r = 1, go to REL_DEB with count = 1; further keys pressed while in HELD are ignored.
REQ-019 REL_DEB: on each tick, if row bit r = 1, increment the count; if row bit r = 0, return to HELD.
REQ-020 REL_DEB: when the count reaches DEB_TICKS, go to IDLE with col = 4'b0000; no flag is raised on release.
REQ-021 value SHALL hold its last loaded code until the next accepted press.
REQ-022 key_flag SHALL never be high on two consecutive cycles, and SHALL be high at most once per press-release cycle.
REQ-023 The debounce counter SHALL be ceil(log2(DEB_TICKS+1)) bits wide and SHALL saturate rather than wrap.
REQ-024 When several keys are pressed simultaneously, the lowest column is found first, then the lowest row within that column.

Reset
REQ-025 While rst = 1: state = IDLE, col = 4'b0000, value = 4'd0, key_flag = 0, tick and debounce counters = 0, synchronizer flops = 4'b1111.
REQ-026 Reset asserted in any state, including PRESS_DEB or HELD, SHALL abort immediately with no key_flag pulse; scanning restarts from IDLE after release.

Verification (SCAN_DIV=4, DEB_TICKS=3)
REQ-027 Press key r=2, c=1 (row = 4'b1011 while col = 4'b1101), held 40 cycles -> exactly one key_flag pulse with value = 4'd9; col returns to 4'b0000 after release and DEB_TICKS ticks.
REQ-028 Press the same key as a 2-tick glitch, then release -> no key_flag; value unchanged; FSM back in IDLE.
REQ-029 Press r=0, c=3 and hold for 200 cycles -> exactly one key_flag with value = 4'd3; no repeats while held.
REQ-030 Simultaneous keys (r=1, c=2) and (r=3, c=0) -> value = 4'd12 (column 0 wins).
REQ-031 Assert rst during PRESS_DEB -> outputs return immediately to the reset values of REQ-025; no key_flag; a later clean press of r=3, c=3 gives value = 4'd15.
REQ-032 Release bounce (row toggles 1,0,1 across ticks in REL_DEB), then a stable release -> FSM returns to HELD, then to IDLE; no extra key_flag.
